// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between a controller (master) and the device-side responder (slave).
interface sdram_responder_if #(
   parameter int SDRAM_DATA = 16,
   parameter int SDRAM_BA   = 2,
   parameter int SDRAM_ROW  = 13
);
   logic                    sdram_cke;
   logic                    sdram_cs_n;
   logic                    sdram_ras_n;
   logic                    sdram_cas_n;
   logic                    sdram_we_n;
   logic [SDRAM_BA-1:0]     sdram_ba;
   logic [SDRAM_ROW-1:0]    sdram_addr;
   logic [SDRAM_DATA/8-1:0] sdram_dqm;
   logic [SDRAM_DATA-1:0]   sdram_dq_in;
   logic [SDRAM_DATA-1:0]   sdram_dq_out;
   logic                    sdram_dq_oe;

   modport master (
      output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_ba, sdram_addr, sdram_dqm, sdram_dq_in,
      input  sdram_dq_out, sdram_dq_oe
   );

   modport slave (
      input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_ba, sdram_addr, sdram_dqm, sdram_dq_in,
      output sdram_dq_out, sdram_dq_oe
   );
endinterface

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: command decode, init tracking, small array, CAS-latency read path.
// Define SDRAM_RESPONDER_CHECK_EN to build in the protocol/timing checker (err/err_code).
//
// state   | meaning
// S_POWER | after reset, waiting for CKE to go high
// S_WAIT  | CKE high, counting power-up cycles until PRE-all
// S_PRE   | precharged, collecting refreshes until LMR
// S_READY | mode programmed, device usable
module sdram_responder #(
   parameter int SDRAM_DATA    = 16,
   parameter int SDRAM_BANK    = 4,
   parameter int SDRAM_BA      = 2,
   parameter int SDRAM_ROW     = 13,
   parameter int SDRAM_COL     = 9,
   parameter int MEM_AW        = 10,
   parameter int CLK_PERIOD    = 10,
   parameter int INIT_WAIT_CYC = 10000,
   parameter int INIT_REF_CNT  = 2,
   parameter int tRP           = 18,
   parameter int tRFC          = 60,
   parameter int tRCD          = 18,
   parameter int tMRD_CYC      = 2
)(
   input  logic                 clk,
   input  logic                 reset,
   sdram_responder_if.slave     bus,
   output logic                 ready,
   output logic [2:0]           mode_cl,
   output logic                 err,
   output logic [2:0]           err_code
);
   typedef enum logic [1:0] {S_POWER, S_WAIT, S_PRE, S_READY} state_t;

   localparam int NBYTE = SDRAM_DATA / 8;

   state_t r_state, w_state_nxt;

   logic [3:0] w_cmd;
   logic       w_act, w_rd, w_wr, w_pre, w_lmr;

   logic [SDRAM_ROW-1:0]  r_row [SDRAM_BANK];
   logic [2:0]            r_mode_cl;
   logic [MEM_AW-1:0]     w_idx;
   logic [SDRAM_DATA-1:0] r_mem [2**MEM_AW];

   logic [1:0]            r_pv;
   logic [SDRAM_DATA-1:0] r_pd [2];
   logic                  r_dq_oe;
   logic [SDRAM_DATA-1:0] r_dq_out;

   assign w_cmd = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
   assign w_act = bus.sdram_cke && (w_cmd == 4'b0011);
   assign w_rd  = bus.sdram_cke && (w_cmd == 4'b0101);
   assign w_wr  = bus.sdram_cke && (w_cmd == 4'b0100);
   assign w_pre = bus.sdram_cke && (w_cmd == 4'b0010);
   assign w_lmr = bus.sdram_cke && (w_cmd == 4'b0000);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_POWER;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_POWER: if (bus.sdram_cke)                  w_state_nxt = S_WAIT;
         S_WAIT:  if (w_pre && bus.sdram_addr[10])    w_state_nxt = S_PRE;
         S_PRE:   if (w_lmr)                          w_state_nxt = S_READY;
         default: w_state_nxt = r_state;
      endcase
   end

   assign ready = (r_state == S_READY);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode_cl <= 3'd0;
         for (int b = 0; b < SDRAM_BANK; b++) r_row[b] <= '0;
      end else begin
         if (w_lmr) r_mode_cl <= bus.sdram_addr[6:4];
         if (w_act) r_row[bus.sdram_ba] <= bus.sdram_addr;
      end
   end

   assign mode_cl = r_mode_cl;

   // Row index uses the latched row even for an idle bank, so stray accesses hit the stale row.
   assign w_idx = MEM_AW'({bus.sdram_ba, r_row[bus.sdram_ba], bus.sdram_addr[SDRAM_COL-1:0]});

   always_ff @(posedge clk) begin
      if (!reset && w_wr) begin
         for (int b = 0; b < NBYTE; b++)
            if (!bus.sdram_dqm[b]) r_mem[w_idx][8*b +: 8] <= bus.sdram_dq_in[8*b +: 8];
      end
   end

   // Two capture stages; the output register taps stage 0 for CL2 and stage 1 for CL3.
   always_ff @(posedge clk) begin
      r_pd[0] <= r_mem[w_idx];
      r_pd[1] <= r_pd[0];
      if (reset) begin
         r_pv     <= 2'b00;
         r_dq_oe  <= 1'b0;
         r_dq_out <= '0;
      end else begin
         r_pv <= {r_pv[0], w_rd};
         if (r_mode_cl == 3'd3) begin
            r_dq_oe <= r_pv[1];
            if (r_pv[1]) r_dq_out <= r_pd[1];
         end else begin
            r_dq_oe <= r_pv[0];
            if (r_pv[0]) r_dq_out <= r_pd[0];
         end
      end
   end

   assign bus.sdram_dq_oe  = r_dq_oe;
   assign bus.sdram_dq_out = r_dq_out;

`ifdef SDRAM_RESPONDER_CHECK_EN
   localparam int RP_CYC  = (tRP  + CLK_PERIOD - 1) / CLK_PERIOD;
   localparam int RFC_CYC = (tRFC + CLK_PERIOD - 1) / CLK_PERIOD;
   localparam int RCD_CYC = (tRCD + CLK_PERIOD - 1) / CLK_PERIOD;
   localparam int BUSY_W  = 8;
   localparam int WAIT_W  = $clog2(INIT_WAIT_CYC + 1);
   localparam int REF_W   = 4;

   logic                  w_ref, w_any;
   logic [WAIT_W-1:0]     r_wait;
   logic [BUSY_W-1:0]     r_busy;
   logic [BUSY_W-1:0]     r_rcd [SDRAM_BANK];
   logic [REF_W-1:0]      r_ref_cnt;
   logic [SDRAM_BANK-1:0] r_open;
   logic                  r_err;
   logic [2:0]            r_err_code;
   logic [2:0]            w_code;

   assign w_ref = bus.sdram_cke && (w_cmd == 4'b0001);
   assign w_any = w_act | w_rd | w_wr | w_pre | w_ref | w_lmr;

   always_comb begin
      w_code = 3'd0;
      if (w_any && r_wait != '0)
         w_code = 3'd1;
      else if ((w_any && r_busy != '0) || ((w_rd || w_wr) && r_rcd[bus.sdram_ba] != '0))
         w_code = 3'd2;
      else if (((w_rd || w_wr) && !r_open[bus.sdram_ba]) || (w_act && r_open[bus.sdram_ba]) ||
               (w_ref && |r_open))
         w_code = 3'd3;
      else if (w_lmr && (!(bus.sdram_addr[6:4] == 3'd2 || bus.sdram_addr[6:4] == 3'd3) ||
                         bus.sdram_addr[2:0] != 3'd0))
         w_code = 3'd4;
      else if (((w_act || w_rd || w_wr) && !ready) ||
               (w_lmr && r_ref_cnt < REF_W'(INIT_REF_CNT)))
         w_code = 3'd5;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait     <= WAIT_W'(INIT_WAIT_CYC);
         r_busy     <= '0;
         r_ref_cnt  <= '0;
         r_open     <= '0;
         r_err      <= 1'b0;
         r_err_code <= 3'd0;
         for (int b = 0; b < SDRAM_BANK; b++) r_rcd[b] <= '0;
      end else begin
         if (bus.sdram_cke && r_wait != '0) r_wait <= r_wait - 1'b1;
         if (w_pre)                r_busy <= BUSY_W'(RP_CYC - 1);
         else if (w_ref)           r_busy <= BUSY_W'(RFC_CYC - 1);
         else if (w_lmr)           r_busy <= BUSY_W'(tMRD_CYC - 1);
         else if (r_busy != '0)    r_busy <= r_busy - 1'b1;
         for (int b = 0; b < SDRAM_BANK; b++) begin
            if (w_act && bus.sdram_ba == SDRAM_BA'(b)) r_rcd[b] <= BUSY_W'(RCD_CYC - 1);
            else if (r_rcd[b] != '0)                   r_rcd[b] <= r_rcd[b] - 1'b1;
         end
         if (w_ref && r_ref_cnt != '1) r_ref_cnt <= r_ref_cnt + 1'b1;
         if (w_act) r_open[bus.sdram_ba] <= 1'b1;
         else if (w_pre) begin
            if (bus.sdram_addr[10]) r_open <= '0;
            else                    r_open[bus.sdram_ba] <= 1'b0;
         end
         if (!r_err && w_code != 3'd0) begin
            r_err      <= 1'b1;
            r_err_code <= w_code;
         end
      end
   end

   assign err      = r_err;
   assign err_code = r_err_code;
`else
   assign err      = 1'b0;
   assign err_code = 3'd0;
`endif
endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench for sdram_responder against an array/queue reference of the device behaviour.
module tb_sdram_responder;
   localparam int INIT_WAIT = 10000;
`ifdef SDRAM_RESPONDER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100,
                          C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

   logic       clk, reset;
   logic       ready, err;
   logic [2:0] mode_cl, err_code;

   sdram_responder_if bus ();

   sdram_responder dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .ready    (ready),
      .mode_cl  (mode_cl),
      .err      (err),
      .err_code (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint      cyc;
      logic [15:0] d;
      bit          chk_d;
   } exp_t;

   int          n_chk = 0;
   int          n_pass = 0;
   longint      cyc = 0;
   int          cl_m = 0;
   int          row_m [4];
   logic [15:0] mem_m [int];
   exp_t        exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // One clock: advance, then compare the read port against the scheduled model output.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         check("rd_oe", 32'(bus.sdram_dq_oe), 32'd1);
         if (exp_q[0].chk_d) check("rd_data", 32'(bus.sdram_dq_out), 32'(exp_q[0].d));
         void'(exp_q.pop_front());
      end else if (bus.sdram_dq_oe !== 1'b0) begin
         check("oe_spurious", 32'(bus.sdram_dq_oe), 32'd0);
      end
   endtask

   task automatic nop(input int n);
      repeat (n) tick();
   endtask

   task automatic cmd(input logic [3:0] c, input int ba, input int addr,
                      input logic [1:0] dqm, input logic [15:0] d);
      {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = c;
      bus.sdram_ba    = 2'(ba);
      bus.sdram_addr  = 13'(addr);
      bus.sdram_dqm   = dqm;
      bus.sdram_dq_in = d;
      tick();
      {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = C_NOP;
   endtask

   function automatic int idx_of(input int ba, input int col);
      return ((ba << 22) + (row_m[ba] << 9) + col) % 1024;
   endfunction

   task automatic do_act(input int ba, input int row);
      row_m[ba] = row;
      cmd(C_ACT, ba, row, 2'b00, 16'h0);
   endtask

   task automatic do_lmr(input int cl);
      cl_m = cl;
      cmd(C_LMR, 0, cl << 4, 2'b00, 16'h0);
   endtask

   task automatic do_wr(input int ba, input int col, input logic [15:0] d, input logic [1:0] dqm_i);
      int          i;
      logic [1:0]  m;
      logic [15:0] w;
      i = idx_of(ba, col);
      m = mem_m.exists(i) ? dqm_i : 2'b00;
      w = mem_m.exists(i) ? mem_m[i] : 16'h0;
      if (!m[0]) w[7:0]  = d[7:0];
      if (!m[1]) w[15:8] = d[15:8];
      cmd(C_WR, ba, col, m, d);
      mem_m[i] = w;
   endtask

   task automatic do_rd(input int ba, input int col);
      exp_t e;
      int   i;
      i = idx_of(ba, col);
      e.chk_d = mem_m.exists(i);
      e.d     = e.chk_d ? mem_m[i] : 16'h0;
      cmd(C_RD, ba, col, 2'b11, 16'h0);
      e.cyc = cyc + longint'(cl_m - 1);
      exp_q.push_back(e);
   endtask

   task automatic do_init(input int cl);
      bus.sdram_cke = 1'b1;
      nop(INIT_WAIT);
      check("init_wait_ready", 32'(ready), 32'd0);
      cmd(C_PRE, 0, 1 << 10, 2'b00, 16'h0);
      nop(1);
      cmd(C_REF, 0, 0, 2'b00, 16'h0);
      nop(5);
      cmd(C_REF, 0, 0, 2'b00, 16'h0);
      nop(5);
      check("pre_lmr_ready", 32'(ready), 32'd0);
      do_lmr(cl);
      nop(1);
      check("init_ready", 32'(ready), 32'd1);
      check("init_mode_cl", 32'(mode_cl), 32'(cl));
      check("init_err", 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      tick();
      check("rst_flush_oe", 32'(bus.sdram_dq_oe), 32'd0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int b, row, col, op;
      reset = 1'b1;
      bus.sdram_cke = 1'b0;
      {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = C_NOP;
      bus.sdram_ba = '0; bus.sdram_addr = '0; bus.sdram_dqm = '0; bus.sdram_dq_in = '0;
      for (int i = 0; i < 4; i++) row_m[i] = 0;
      tick(); tick();
      reset = 1'b0;
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_mode_cl", 32'(mode_cl), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_dq_oe", 32'(bus.sdram_dq_oe), 32'd0);
      check("rst_dq_out", 32'(bus.sdram_dq_out), 32'd0);

      do_init(2);

      // Masked write over a known word, then CL2 read.
      do_act(1, 5);
      nop(1);
      do_wr(1, 3, 16'h1234, 2'b00);
      do_wr(1, 3, 16'hA5A5, 2'b01);
      do_rd(1, 3);
      nop(3);

      // CL3, back-to-back reads, and write right behind a read to the same word.
      do_lmr(3);
      nop(1);
      check("cl3_mode", 32'(mode_cl), 32'd3);
      for (int c = 0; c < 4; c++) do_wr(1, c, 16'(32'hC0DE + c * 32'h1111), 2'b00);
      do_rd(1, 3);
      nop(4);
      for (int c = 0; c < 4; c++) do_rd(1, c);
      do_rd(1, 2);
      do_wr(1, 2, 16'hBEEF, 2'b00);
      do_rd(1, 2);
      nop(5);

      for (int it = 0; it < 20; it++) begin
         nop(4);
         do_lmr(2 + int'($urandom_range(1)));
         nop(1);
         b   = int'($urandom_range(3));
         row = int'($urandom_range(8191));
         cmd(C_PRE, b, 0, 2'b00, 16'h0);
         nop(1);
         do_act(b, row);
         nop(1);
         for (int k = 0; k < 10; k++) begin
            col = int'($urandom_range(7));
            op  = int'($urandom_range(1));
            if (op == 0 || !mem_m.exists(idx_of(b, col)))
               do_wr(b, col, 16'($urandom), 2'($urandom));
            else
               do_rd(b, col);
            nop(int'($urandom_range(2)));
         end
      end
      nop(4);
      check("rand_err", 32'(err), 32'd0);

      // REF too soon after REF.
      cmd(C_PRE, 0, 1 << 10, 2'b00, 16'h0);
      nop(1);
      cmd(C_REF, 0, 0, 2'b00, 16'h0);
      nop(2);
      cmd(C_REF, 0, 0, 2'b00, 16'h0);
      nop(1);
      check("trfc_err", 32'(err), 32'(CHK));
      check("trfc_code", 32'(err_code), CHK ? 32'd2 : 32'd0);

      // Reset one cycle after a READ kills the pending data.
      nop(5);
      do_rd(0, 0);
      do_reset();
      nop(4);
      check("rst2_ready", 32'(ready), 32'd0);
      check("rst2_err", 32'(err), 32'd0);
      check("rst2_code", 32'(err_code), 32'd0);
      check("rst2_mode_cl", 32'(mode_cl), 32'd0);
      for (int i = 0; i < 4; i++) row_m[i] = 0;

      do_init(2);
      do_rd(2, 0);
      nop(3);
      check("idle_rd_err", 32'(err), 32'(CHK));
      check("idle_rd_code", 32'(err_code), CHK ? 32'd3 : 32'd0);
      do_lmr(4);
      nop(2);
      check("cl4_mode", 32'(mode_cl), 32'd4);
      check("cl4_code_kept", 32'(err_code), CHK ? 32'd3 : 32'd0);
      check("cl4_err", 32'(err), 32'(CHK));
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDRAM device-side responder for simulation and on-FPGA loopback of the SDRAM controller. It decodes the command bus driven by the controller, tracks the power-up/initialization sequence, mode register and per-bank row state, and serves single-beat reads and writes from a small internal array with the programmed CAS latency. With checking compiled in, it also flags protocol and timing violations.

## Interface
- SDRAM_DATA, 16, DQ width (multiple of 8)
- SDRAM_BANK, 4, bank count
- SDRAM_BA, 2, BA width
- SDRAM_ROW, 13, row/address width
- SDRAM_COL, 9, column width
- MEM_AW, 10, internal array address width (2^MEM_AW words)
- CLK_PERIOD, 10, clock period in ns
- INIT_WAIT_CYC, 10000, minimum CKE-high cycles before the first non-NOP command
- INIT_REF_CNT, 2, refreshes required before LMR
- tRP, 18 / tRFC, 60 / tRCD, 18, timings in ns; cycles = ceil(t/CLK_PERIOD)
- tMRD_CYC, 2, LMR-to-command cycles

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command bus
- sdram_ba  in  SDRAM_BA  bank address
- sdram_addr  in  SDRAM_ROW  row/column/mode address
- sdram_dqm  in  SDRAM_DATA/8  write byte mask (1 = masked)
- sdram_dq_in  in  SDRAM_DATA  write data
- sdram_dq_out  out  SDRAM_DATA  read data
- sdram_dq_oe  out  1  read data valid/drive enable
- ready  out  1  initialization complete
- mode_cl  out  3  programmed CAS latency
- err  out  1  sticky error
- err_code  out  3  code of the first error

## Operation
- Command decode {cs_n,ras_n,cas_n,we_n} when cke=1: 1xxx INH, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 REF, 0000 LMR, 0110 BST (treated as NOP). cke=0: all inputs ignored.
- Init FSM: S_POWER → (cke=1) S_WAIT, counting CKE-high cycles → PRE with addr[10]=1 → S_PRE → each REF increments ref_cnt → LMR → S_READY. ready is high in S_READY only.
- LMR: mode_cl ← addr[6:4], burst length ← addr[2:0]. Only CL 2/3 and BL=1 (code 000) are legal. LMR is accepted even if ref_cnt < INIT_REF_CNT (error 5 flagged).
- ACT: open bank ba with row addr. PRE: addr[10]=1 closes all banks, else closes bank ba.
- Array index = low MEM_AW bits of {ba, open_row[ba], addr[SDRAM_COL-1:0]}.
- WRITE: data is sampled on the command edge; byte lanes with dqm=1 are left unchanged.
- READ: array word is pushed into a CL-deep pipeline; dqm is ignored on reads.
- Errors (only with checking; first error sets err_code, err is sticky until reset):
  - 1: non-NOP/INH command before INIT_WAIT_CYC.
  - 2: command while the global busy counter (tRP/tRFC/tMRD) is nonzero, or READ/WRITE while the bank tRCD counter is nonzero.
  - 3: READ/WRITE to an idle bank, ACT to an open bank, or REF with any bank open.
  - 4: illegal CL or BL in LMR.
  - 5: ACT/READ/WRITE before ready, or LMR with too few refreshes.
- Illegal commands still update state where defined (e.g. READ to an idle bank returns the word at the stale row index).

## Timing
- Reset values: dq_out=0, dq_oe=0, ready=0, mode_cl=0, err=0, err_code=0, all banks idle, ref_cnt=0, counters=0. Array contents are not reset.
- READ sampled at edge E0: dq_oe/dq_out are registered and update at edge E(CL-1), so data is stable at edge E(CL). dq_oe is high for exactly one cycle per READ.
- Back-to-back READs every cycle produce back-to-back data. A WRITE to the same address as an in-flight READ does not alter the already-captured read data.
- PRE/REF/LMR load the busy counter with tRP/tRFC/tMRD cycles minus 1; the next command is legal once the counter reaches 0.
- Reset mid-operation flushes the read pipeline (dq_oe=0 on the next cycle) and returns the FSM to S_POWER.

## Configuration
- SDRAM_RESPONDER_CHECK_EN defined: busy counters, tRCD counters and error logic are present.
- Not defined: err and err_code are tied to 0, and timing counters are removed. Decode, init FSM, array and read latency behave identically.

## Test plan
- Reset, cke=1, INIT_WAIT_CYC NOPs, PRE-all, 2×REF spaced tRFC, LMR CL=2 BL=1 → ready=1 tMRD cycles later, err=0.
- ACT b1 row 5, WRITE col 3 data 0xA5A5 dqm=01, then READ → dq_oe high at edge E1, dq_out=0xA5xx (low byte holds the old value).
- LMR CL=3, READ → data valid at edge E3; 4 consecutive READs → 4 consecutive dq_oe cycles.
- REF issued 3 cycles after the previous REF (tRFC=6) → err=1, err_code=2.
- READ to an idle bank after init → err_code=3; LMR CL=4 → err_code stays 3 (first error kept).
- Reset asserted one cycle after READ → no dq_oe pulse, ready=0, err=0.
